// File: rtl/dm_arbiter.sv
// Shares the data memory between the CPU MEM stage and a DMA/debug burst port; optional trace via DM_ARB_TRACE_EN.
// Latency: CPU ack 2 cycles after the IDLE grant; DMA beats t+1..t+N, done at t+N+1, read data one cycle behind its beat.
// Backpressure: requests are levels held until ack/done; CPU has priority, DMA is forced in after STARVE_LIMIT CPU grants.
module dm_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [1:0]         cpu_sel,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic [31:0]        cpu_pcadd4,
    output logic               cpu_ack,
    output logic [31:0]        cpu_rdata,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [31:0]        dma_addr,
    input  logic [BURST_W-1:0] dma_len,
    input  logic [31:0]        dma_wdata,
    output logic               dma_beat,
    output logic               dma_rvalid,
    output logic [31:0]        dma_rdata,
    output logic               dma_done,
    output logic [31:0]        dm_addr,
    output logic [31:0]        dm_di,
    output logic               dm_en,
    output logic [1:0]         dm_sel,
    output logic [31:0]        dm_pcadd4,
    input  logic [31:0]        dm_do
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_RESP, DMA_ACC, DMA_DONE} state_t;

    state_t             state_q, state_d;
    logic               c_we_q, c_we_d;
    logic [1:0]         c_sel_q, c_sel_d;
    logic [31:0]        c_addr_q, c_addr_d;
    logic [31:0]        c_wdata_q, c_wdata_d;
    logic [31:0]        c_pc_q, c_pc_d;
    logic [31:0]        d_base_q, d_base_d;
    logic [BURST_W-1:0] d_len_q, d_len_d;
    logic               d_we_q, d_we_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        di_q, di_d;
    logic [1:0]         sel_q, sel_d;
    logic [31:0]        pc_q, pc_d;
    logic               en_d;
    logic [31:0]        cpu_rdata_q;
    logic [31:0]        dma_rdata_q;
    logic               dma_rvalid_q;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^dma_addr[1:0];

    always_comb begin
        state_d   = state_q;
        c_we_d    = c_we_q;
        c_sel_d   = c_sel_q;
        c_addr_d  = c_addr_q;
        c_wdata_d = c_wdata_q;
        c_pc_d    = c_pc_q;
        d_base_d  = d_base_q;
        d_len_d   = d_len_q;
        d_we_d    = d_we_q;
        beat_d    = beat_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        di_d      = di_q;
        sel_d     = sel_q;
        pc_d      = pc_q;
        en_d      = 1'b0;
        cpu_ack   = 1'b0;
        dma_beat  = 1'b0;
        dma_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && (!dma_req || starve_q < SW'(STARVE_LIMIT))) begin
                    c_we_d    = cpu_we;
                    c_sel_d   = cpu_sel;
                    c_addr_d  = cpu_addr;
                    c_wdata_d = cpu_wdata;
                    c_pc_d    = cpu_pcadd4;
                    if (dma_req && starve_q < SW'(STARVE_LIMIT))
                        starve_d = starve_q + 1'b1;
                    state_d = CPU_ACC;
                end else if (dma_req) begin
                    d_base_d = {dma_addr[31:2], 2'b00};
                    d_len_d  = dma_len;
                    d_we_d   = dma_we;
                    beat_d   = '0;
                    starve_d = '0;
                    state_d  = DMA_ACC;
                end
            end
            CPU_ACC: begin
                addr_d  = c_addr_q;
                di_d    = c_wdata_q;
                sel_d   = c_sel_q;
                pc_d    = c_pc_q;
                en_d    = c_we_q;
                state_d = CPU_RESP;
            end
            CPU_RESP: begin
                cpu_ack = 1'b1;
                state_d = IDLE;
            end
            DMA_ACC: begin
                // Word stride; the sum wraps naturally past 0xFFFFFFFC.
                addr_d   = d_base_q + {{(30-BURST_W){1'b0}}, beat_q, 2'b00};
                di_d     = dma_wdata;
                sel_d    = 2'b00;
                pc_d     = 32'h0;
                en_d     = d_we_q;
                dma_beat = 1'b1;
                beat_d   = beat_q + 1'b1;
                if (beat_q == d_len_q)
                    state_d = DMA_DONE;
            end
            DMA_DONE: begin
                dma_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data/size are registered so they hold their last value when the DM is idle.
    assign dm_addr    = addr_d;
    assign dm_di      = di_d;
    assign dm_sel     = sel_d;
    assign dm_pcadd4  = pc_d;
    assign dm_en      = en_d & ~reset;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            c_we_q       <= 1'b0;
            c_sel_q      <= 2'b00;
            c_addr_q     <= '0;
            c_wdata_q    <= '0;
            c_pc_q       <= '0;
            d_base_q     <= '0;
            d_len_q      <= '0;
            d_we_q       <= 1'b0;
            beat_q       <= '0;
            starve_q     <= '0;
            addr_q       <= '0;
            di_q         <= '0;
            sel_q        <= 2'b00;
            pc_q         <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_we_q       <= c_we_d;
            c_sel_q      <= c_sel_d;
            c_addr_q     <= c_addr_d;
            c_wdata_q    <= c_wdata_d;
            c_pc_q       <= c_pc_d;
            d_base_q     <= d_base_d;
            d_len_q      <= d_len_d;
            d_we_q       <= d_we_d;
            beat_q       <= beat_d;
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            di_q         <= di_d;
            sel_q        <= sel_d;
            pc_q         <= pc_d;
            if (state_q == CPU_ACC)
                cpu_rdata_q <= dm_do;
            dma_rvalid_q <= (state_q == DMA_ACC) && !d_we_q;
            if ((state_q == DMA_ACC) && !d_we_q)
                dma_rdata_q <= dm_do;
        end
    end

`ifdef DM_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (state_q == IDLE && state_d == CPU_ACC)
                $display("ARB cpu @%h", cpu_addr);
            else if (state_q == IDLE && state_d == DMA_ACC)
                $display("ARB dma @%h", {dma_addr[31:2], 2'b00});
            if (state_q == DMA_ACC && dm_en)
                $display("DMA *%h <= %h", dm_addr, dm_di);
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter with a small little-endian sign-extending DM model and per-scenario scoreboards.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_sel;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pcadd4;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_beat, dma_rvalid, dma_done;
    logic [31:0] dma_rdata;
    logic [31:0] dm_addr, dm_di, dm_pcadd4, dm_do;
    logic        dm_en;
    logic [1:0]  dm_sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(4), .BURST_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_pcadd4(cpu_pcadd4), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_beat(dma_beat), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .dm_addr(dm_addr), .dm_di(dm_di), .dm_en(dm_en), .dm_sel(dm_sel),
        .dm_pcadd4(dm_pcadd4), .dm_do(dm_do)
    );

    // DM model: 64 words, little-endian lanes, sign-extending half/byte reads.
    logic [31:0] mem [64];
    logic        mem_clr;
    logic [31:0] rd_w;
    logic [15:0] rd_h;
    logic [7:0]  rd_b;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (dm_en) begin
            case (dm_sel)
                2'b01: begin
                    if (dm_addr[1]) mem[dm_addr[7:2]][31:16] <= dm_di[15:0];
                    else            mem[dm_addr[7:2]][15:0]  <= dm_di[15:0];
                end
                2'b10:   mem[dm_addr[7:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_di[7:0];
                default: mem[dm_addr[7:2]] <= dm_di;
            endcase
        end
    end

    always_comb begin
        rd_w  = mem[dm_addr[7:2]];
        rd_h  = dm_addr[1] ? rd_w[31:16] : rd_w[15:0];
        rd_b  = rd_w[{dm_addr[1:0], 3'b000} +: 8];
        dm_do = rd_w;
        case (dm_sel)
            2'b01:   dm_do = {{16{rd_h[15]}}, rd_h};
            2'b10:   dm_do = {{24{rd_b[7]}}, rd_b};
            default: dm_do = rd_w;
        endcase
    end

    logic [166:0] all_outs;
    assign all_outs = {cpu_ack, cpu_rdata, dma_beat, dma_rvalid, dma_rdata, dma_done,
                       dm_addr, dm_di, dm_en, dm_sel, dm_pcadd4};

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t bq[$];
    exp_t cq[$];
    bit   gq[$];

    task automatic cpu_drive(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] pc);
        cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = addr;
        cpu_wdata = wdata; cpu_pcadd4 = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++; $display("FAIL reset_outs got=%h want=0", all_outs);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++; $display("FAIL idle_outs got=%h want=0", all_outs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_store_load();
        logic        we_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sel_t  [6] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
        logic [31:0] addr_t [6] = '{32'h10, 32'h13, 32'h11, 32'h11, 32'h10, 32'h12};
        logic [31:0] wd_t   [6] = '{32'h12345678, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0};
        logic [31:0] exp_t_ [6] = '{32'h0, 32'h00000012, 32'h0, 32'hFFFFFF80, 32'h12348078, 32'h00001234};
        for (int k = 0; k < 6; k++) begin
            int cyc;
            bit got;
            exp_t e;
            cpu_drive(we_t[k], sel_t[k], addr_t[k], wd_t[k], 32'h400 + 32'(4 * k));
            cq.push_back('{2, addr_t[k], exp_t_[k]});
            cyc = 0; got = 0;
            while (!got && cyc < 10) begin
                @(negedge clk);
                if (cyc == 1) begin
                    n_vec++;
                    if (dm_en !== we_t[k] || dm_addr !== addr_t[k] || dm_sel !== sel_t[k] ||
                        dm_pcadd4 !== 32'h400 + 32'(4 * k)) begin
                        n_err++;
                        $display("FAIL cpu_drive[%0d] en=%b addr=%h sel=%b pc=%h want en=%b addr=%h sel=%b pc=%h",
                                 k, dm_en, dm_addr, dm_sel, dm_pcadd4, we_t[k], addr_t[k], sel_t[k],
                                 32'h400 + 32'(4 * k));
                    end
                end
                if (cpu_ack) begin
                    e = cq.pop_front();
                    got = 1;
                    n_vec++;
                    if (cyc != e.cyc || (!we_t[k] && cpu_rdata !== e.d)) begin
                        n_err++;
                        $display("FAIL cpu_ack[%0d] cyc=%0d rdata=%h want cyc=%0d rdata=%h",
                                 k, cyc, cpu_rdata, e.cyc, e.d);
                    end
                end
                cyc++;
                @(posedge clk); #1;
                if (got) cpu_req = 1'b0;
            end
            if (!got) begin
                n_vec++; n_err++; cpu_req = 1'b0;
                $display("FAIL cpu_timeout[%0d] no ack within 10 cycles", k);
            end
            if (k == 0) begin
                n_vec++;
                if (mem[4] !== 32'h12345678) begin
                    n_err++; $display("FAIL cpu_store mem=%h want=12345678", mem[4]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int cyc;
        reset = 1'b1;
        cpu_drive(1'b0, 2'b00, 32'h10, 32'h0, 32'h0);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_len = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) gq.push_back(1'b0);
            gq.push_back(1'b1);
        end
        cyc = 0;
        while (gq.size() != 0 && cyc < 100) begin
            @(negedge clk);
            if (cpu_ack || dma_done) begin
                bit g, e;
                g = dma_done;
                e = gq.pop_front();
                n_vec++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL grant_order got=%s want=%s", g ? "dma" : "cpu", e ? "dma" : "cpu");
                end
            end
            cyc++;
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        if (gq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL grant_timeout %0d grants missing", gq.size());
            gq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_dma_write(input logic [31:0] base_in, input int len, input logic [31:0] d0);
        logic [31:0] base;
        int cyc, beats, rv;
        bit done, seen;
        exp_t e;
        base = {base_in[31:2], 2'b00};
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = base_in; dma_len = len[3:0]; dma_wdata = d0;
        for (int i = 0; i <= len; i++) bq.push_back('{i + 1, base + 32'(4 * i), d0 + 32'(i)});
        cyc = 0; beats = 0; rv = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            seen = dma_beat;
            if (dma_rvalid) rv++;
            if (dma_beat) begin
                beats++;
                if (bq.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL dma_wbeat extra beat at cyc=%0d", cyc);
                end else begin
                    e = bq.pop_front();
                    n_vec++;
                    if (cyc != e.cyc || dm_addr !== e.a || dm_di !== e.d || dm_en !== 1'b1 ||
                        dm_sel !== 2'b00 || dm_pcadd4 !== 32'h0) begin
                        n_err++;
                        $display("FAIL dma_wbeat cyc=%0d addr=%h di=%h en=%b sel=%b pc=%h want cyc=%0d addr=%h di=%h en=1 sel=00 pc=0",
                                 cyc, dm_addr, dm_di, dm_en, dm_sel, dm_pcadd4, e.cyc, e.a, e.d);
                    end
                end
            end
            if (dma_done) begin
                done = 1;
                n_vec++;
                if (cyc != len + 2) begin
                    n_err++; $display("FAIL dma_wdone cyc=%0d want=%0d", cyc, len + 2);
                end
            end
            cyc++;
            @(posedge clk); #1;
            if (seen) dma_wdata = dma_wdata + 1;
        end
        dma_req = 1'b0;
        if (!done) begin
            n_vec++; n_err++; $display("FAIL dma_wtimeout no done within 40 cycles");
        end
        n_vec++;
        if (beats != len + 1 || rv != 0) begin
            n_err++; $display("FAIL dma_wcount beats=%0d rvalid=%0d want beats=%0d rvalid=0", beats, rv, len + 1);
        end
        bq.delete();
        for (int i = 0; i <= len; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            n_vec++;
            if (mem[a[7:2]] !== d0 + 32'(i)) begin
                n_err++; $display("FAIL dma_wmem @%h got=%h want=%h", a, mem[a[7:2]], d0 + 32'(i));
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_dma_read_cpu_wait();
        int cyc, done_cyc;
        bit got;
        exp_t e;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; dma_len = 4'd3;
        for (int i = 0; i < 4; i++) bq.push_back('{i + 2, 32'h0, 32'(i + 1)});
        cyc = 0; done_cyc = -1; got = 0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            if (dma_rvalid) begin
                if (bq.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL dma_rvalid extra at cyc=%0d", cyc);
                end else begin
                    e = bq.pop_front();
                    n_vec++;
                    if (cyc != e.cyc || dma_rdata !== e.d) begin
                        n_err++;
                        $display("FAIL dma_rvalid cyc=%0d data=%h want cyc=%0d data=%h", cyc, dma_rdata, e.cyc, e.d);
                    end
                end
            end
            if (dma_done) begin
                done_cyc = cyc;
                n_vec++;
                if (cyc != 5) begin
                    n_err++; $display("FAIL dma_rdone cyc=%0d want=5", cyc);
                end
            end
            if (cpu_ack) begin
                got = 1;
                n_vec++;
                if (done_cyc < 0 || cyc != done_cyc + 3 || cpu_rdata !== 32'h2) begin
                    n_err++;
                    $display("FAIL cpu_wait ack_cyc=%0d done_cyc=%0d rdata=%h want ack_cyc=8 rdata=00000002",
                             cyc, done_cyc, cpu_rdata);
                end
            end
            if (cyc == 2) cpu_drive(1'b0, 2'b00, 32'h24, 32'h0, 32'h0);
            cyc++;
            @(posedge clk); #1;
            if (done_cyc >= 0) dma_req = 1'b0;
            if (got) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        if (!got) begin
            n_vec++; n_err++; $display("FAIL cpu_wait_timeout no ack within 30 cycles");
        end
        n_vec++;
        if (bq.size() != 0) begin
            n_err++; $display("FAIL dma_rcount %0d read beats missing, want 0", bq.size());
        end
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] pre;
        int cyc, acks;
        bit got;
        pre = mem[12];
        cpu_drive(1'b1, 2'b00, 32'h30, 32'hDEADBEEF, 32'h500);
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dm_en !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_en got=%b want=0", dm_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_vec++;
                if (all_outs !== '0) begin
                    n_err++; $display("FAIL rst_mid_outs got=%h want=0", all_outs);
                end
            end
            if (cpu_ack) acks++;
        end
        n_vec++;
        if (acks != 0 || mem[12] !== pre) begin
            n_err++; $display("FAIL rst_mid_nowrite acks=%0d mem=%h want acks=0 mem=%h", acks, mem[12], pre);
        end
        @(posedge clk); #1;
        cpu_drive(1'b0, 2'b00, 32'h30, 32'h0, 32'h0);
        cyc = 0; got = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1;
                n_vec++;
                if (cyc != 2 || cpu_rdata !== pre) begin
                    n_err++; $display("FAIL rst_mid_reload cyc=%0d rdata=%h want cyc=2 rdata=%h", cyc, cpu_rdata, pre);
                end
            end
            cyc++;
            @(posedge clk); #1;
            if (got) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        if (!got) begin
            n_vec++; n_err++; $display("FAIL rst_mid_timeout no ack after reset");
        end
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 2'b00; cpu_addr = '0; cpu_wdata = '0; cpu_pcadd4 = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
        test_reset();
        test_cpu_store_load();
        test_starvation();
        test_dma_write(32'h23, 3, 32'h1);
        test_dma_read_cpu_wait();
        test_dma_write(32'hFFFF_FFF8, 15, 32'h100);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

- Shares the single data memory between two requesters: the CPU MEM stage (single word/half/byte accesses) and a DMA/debug port (word bursts).
- Sits between both requesters and the DM; it drives the DM's address, write data, write enable, size select and PC-trace inputs.
- Arbitration is fixed-priority CPU with a starvation guard for DMA.
- Every access is sequenced through a registered FSM, with a registered response.

## Interface
- `STARVE_LIMIT`, default 4: consecutive CPU grants that may occur while DMA is waiting before DMA is forced in.
- `BURST_W`, default 4: width of the burst length field; max burst is 2^BURST_W words.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request, level, held until `cpu_ack`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_sel` in 2: size select. 00 = word, 01 = half, 10 = byte, 11 = word.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: store data, in the low bits for half/byte.
- `cpu_pcadd4` in 32: PC+4 of the issuing instruction, used for the write trace.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: load data, sign-extended by the DM, valid while `cpu_ack` = 1.
- `dma_req` in 1: burst request, level, held until `dma_done`.
- `dma_we` in 1: burst direction, 1 = write to DM.
- `dma_addr` in 32: burst base byte address; bits [1:0] are ignored.
- `dma_len` in BURST_W: burst beats minus 1.
- `dma_wdata` in 32: current write beat.
- `dma_beat` out 1: the current beat is consumed this cycle; the source advances `dma_wdata` at the next edge.
- `dma_rvalid` out 1: read beat valid, registered.
- `dma_rdata` out 32: read beat data.
- `dma_done` out 1: one-cycle burst completion pulse.
- `dm_addr` out 32: to DM Address.
- `dm_di` out 32: to DM DI.
- `dm_en` out 1: to DM En.
- `dm_sel` out 2: to DM DMsel.
- `dm_pcadd4` out 32: to DM PCadd4.
- `dm_do` in 32: from DM DO. This path is combinational in the DM.

## Operation
- **States:** IDLE, CPU_ACC, CPU_RESP, DMA_ACC, DMA_DONE.
- **IDLE:**
  - If `cpu_req` && (!`dma_req` || starve_cnt < STARVE_LIMIT): latch `cpu_we`, `cpu_sel`, `cpu_addr`, `cpu_wdata` and `cpu_pcadd4`, then go to CPU_ACC.
    - starve_cnt increments if `dma_req` = 1, saturating at STARVE_LIMIT.
  - Else if `dma_req`: latch the base as {`dma_addr`[31:2], 2'b00}, plus `dma_len` and `dma_we`. Clear beat_cnt and starve_cnt, then go to DMA_ACC.
  - Else remain in IDLE.
- **CPU_ACC:**
  - Drive the DM from the latched request: `dm_en` = latched we, `dm_sel` = latched sel.
  - Capture `dm_do` into `cpu_rdata`, then go to CPU_RESP.
- **CPU_RESP:** `cpu_ack` = 1, then go to IDLE. A `cpu_req` still seen in the following IDLE cycle is treated as a new request.
- **DMA_ACC:**
  - DM drive: `dm_addr` = base + 4·beat_cnt (32-bit wrap), `dm_sel` = 00, `dm_en` = latched we, `dm_di` = `dma_wdata`, `dm_pcadd4` = 0.
  - `dma_beat` = 1.
  - On reads, register `dm_do` into `dma_rdata` and set `dma_rvalid` next cycle.
  - Increment beat_cnt; when beat_cnt == latched len, go to DMA_DONE.
  - A burst is atomic: a CPU request waits and is not preempted.
- **DMA_DONE:** `dma_done` = 1; the last `dma_rvalid` coincides with it. Then go to IDLE.
- **Idle DM drive:** `dm_en` = 0 in IDLE, CPU_RESP and DMA_DONE. `dm_addr`, `dm_di` and `dm_sel` hold their last driven values.
- **Address handling:** misaligned addresses are passed through untouched; the DM ignores the low bits per size.

## Timing
- **Reset values:**
  - All outputs 0; state is IDLE; starve_cnt and beat_cnt are 0.
  - `dm_en` is gated by !`reset`, so a write in flight during the reset cycle is suppressed and never acked.
- **CPU latency:** request seen in IDLE at cycle t; the DM is written at the end of t+1; `cpu_ack`/`cpu_rdata` are valid in t+2. Peak rate is 1 access per 3 cycles.
- **DMA burst of N beats:** beats run in t+1..t+N; `dma_done` is at t+N+1; read data lags its beat by 1 cycle.
- **Simultaneous requests:** CPU wins until starve_cnt reaches STARVE_LIMIT; DMA then wins at the next IDLE.
- **Burst length:** `dma_len` = 0 gives a single-beat burst; the maximum is 2^BURST_W beats. The base wrapping past 0xFFFFFFFC wraps to 0.

## Configuration
- **`DM_ARB_TRACE_EN` defined:**
  - Each grant prints `"ARB cpu|dma @%h"` with the address.
  - Each DMA write beat prints `"DMA *%h <= %h"`.
  - CPU writes are traced by the DM via `dm_pcadd4`.
- **`DM_ARB_TRACE_EN` undefined:** no `$display` calls; logic and timing are identical.

## Test plan
- **CPU store/load:** CPU word store 0x12345678 to 0x10, then byte load (sel = 10) at 0x13 → ack at t+2 for each; rdata = 0x00000012.
- **Simultaneous requests:** `cpu_req` and `dma_req` both high at reset release, CPU re-requesting back-to-back → 4 CPU grants, then DMA is granted; starve_cnt is 0 after.
- **DMA write burst:** `dma_len` = 3 at 0x20 with wdata 1,2,3,4 → `dma_beat` high 4 cycles, DM words 0x20..0x2C = 1..4, `dma_done` at t+5.
- **DMA read during CPU wait:** DMA read burst of the same words while `cpu_req` is raised mid-burst → `dma_rvalid` ×4 with data 1..4; `cpu_ack` only after `dma_done`.
- **Reset mid-access:** `reset` asserted in CPU_ACC of a store → no DM write, no ack, all outputs 0, state IDLE next cycle.
